voice_allocator: RTL
====================

Name: voice_allocator

Overview:
Polyphonic voice allocator placed between the MIDI decoder and the synth engine. It accepts note-on/note-off events through a valid/ready handshake and maps each one to a voice slot. The mapping prefers the same-key voice, then a free voice, then the oldest releasing voice, and finally steals the oldest held voice. It drives keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on and cur_vel_off into the engine, and reads back voice_free from the envelope generator.

Parameters:
VOICES, 8, number of voice slots
V_WIDTH, 3, log2(VOICES)
AGE_W, 4, width of per-voice saturating age counter
NOTE_HOLD, 64, OSC_CLK cycles note_on is held high (must span one full engine voice-scan frame)

Ports:
OSC_CLK  in  1  system clock, all logic rising-edge
iRST  in  1  synchronous active-high reset
ev_valid  in  1  event request
ev_ready  out  1  allocator idle, event accepted when ev_valid&ev_ready
ev_is_on  in  1  1=note-on, 0=note-off
ev_key  in  8  MIDI key number
ev_vel  in  8  velocity
panic  in  1  all-notes-off pulse
voice_free  in  VOICES  per-voice envelope-idle flags from envelope generator
keys_on  out  VOICES  per-voice key-held flags
note_on  out  1  trigger strobe to engine
cur_key_adr  out  V_WIDTH  selected voice
cur_key_val  out  8  key of selected voice
cur_vel_on  out  8  note-on velocity
cur_vel_off  out  8  note-off velocity
busy_err  out  1  sticky: a steal of a held voice occurred (cleared by reset)

Behaviour:
- Reset (sync, iRST=1): state IDLE.
  - ev_ready=1; keys_on=0, note_on=0, cur_key_adr=0, cur_key_val=0, cur_vel_on=8'hFF, cur_vel_off=0, busy_err=0.
  - All key[v]=0, assigned[v]=0, age[v]=max.
  - Reset mid-operation aborts the event with no output pulse.
- Per-voice state: key[v] (8b), assigned[v] (voice has ever held a key since reset), age[v] (AGE_W, saturating).
- Note-on with ev_vel==0 is treated as note-off with cur_vel_off=0.
- FSM IDLE -> SCAN -> DECIDE -> (ISSUE) -> IDLE.
- IDLE:
  - ev_ready=1.
  - On handshake: latch ev_is_on/ev_key/ev_vel, ev_ready=0, idx=0, clear candidates, go SCAN.
- SCAN:
  - Examines voice idx, one per cycle, for VOICES cycles (idx wraps to 0 after VOICES-1, then go DECIDE).
  - Tracks four candidates, each keeping the first (lowest-index) hit on ties:
    - match: assigned[idx] && key[idx]==latched key
    - free: voice_free[idx] && !keys_on[idx]
    - oldest releasing: !keys_on[idx], maximum age
    - oldest held: maximum age
- DECIDE, note-on (1 cycle):
  - Target priority: match > free > oldest releasing > oldest held.
  - If the target is oldest held, set busy_err=1.
  - Then: key[t]=key, assigned[t]=1, age[t]=0, all other ages +1 saturating at 2^AGE_W-1.
  - Then: keys_on[t]=1, cur_key_adr=t, cur_key_val=key, cur_vel_on=vel, go ISSUE.
- DECIDE, note-off:
  - Target is a match with keys_on=1. If found: keys_on[t]=0, cur_key_adr=t, cur_vel_off=vel.
  - Go IDLE in either case; an unmatched note-off is silently dropped.
- ISSUE:
  - note_on=1 for exactly NOTE_HOLD cycles, counter-based.
  - cur_* outputs stay stable through ISSUE, then go IDLE.
- Latency (accept at cycle 0):
  - Scan occupies cycles 1..VOICES; DECIDE is VOICES+1.
  - keys_on/cur_* update visible at VOICES+2.
  - note_on high over VOICES+2..VOICES+1+NOTE_HOLD.
  - ev_ready=1 at VOICES+2+NOTE_HOLD (note-on) or VOICES+2 (note-off).
- voice_free is sampled live during SCAN. A change after a voice has been scanned is ignored for that event.
- panic:
  - Any state except ISSUE: next cycle keys_on=0, state IDLE, pending event discarded.
  - During ISSUE: deferred until ISSUE ends, then applied.
  - panic and handshake in the same cycle: panic wins, and the event is not accepted.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then note-on key=60 vel=100 with all voice_free=1 -> cur_key_adr=0, keys_on=8'h01, note_on high 64 cycles starting cycle 10, ev_ready=1 at cycle 74.
- Note-on 60, 62, 64 -> voices 0,1,2. Note-off 62 vel=40 -> keys_on=8'h05, cur_key_adr=1, cur_vel_off=40, no note_on pulse.
- Note-on 60 again while voice 0 is held -> retrigger on voice 0, keys_on unchanged, note_on pulses; note-on vel=0 key=60 -> keys_on[0]=0.
- Fill 8 voices with keys 60..67, voice_free=0 -> note-on 70 steals voice 0 (oldest), busy_err=1, key[0]=70.
- 8 voices allocated, voices 3 and 5 released (keys_on=0, voice_free=0), voice 5 older -> note-on 80 -> cur_key_adr=5, busy_err stays 0.
- panic asserted during SCAN -> keys_on=0 next cycle, no note_on, ev_ready=1. iRST asserted during ISSUE -> note_on=0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto voice slots, preferring
// the same-key voice, then a free one, then the oldest releasing, then the oldest held.
//
// state  | meaning
// IDLE   | ev_ready high, waiting for an event
// SCAN   | one voice per cycle, collecting target candidates
// DECIDE | commit the chosen voice and update outputs
// ISSUE  | note_on held high for NOTE_HOLD cycles
module voice_allocator #(
    parameter int VOICES    = 8,
    parameter int V_WIDTH   = 3,
    parameter int AGE_W     = 4,
    parameter int NOTE_HOLD = 64
) (
    input  logic               OSC_CLK,
    input  logic               iRST,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_is_on,
    input  logic [7:0]         ev_key,
    input  logic [7:0]         ev_vel,
    input  logic               panic,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  keys_on,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off,
    output logic               busy_err
);
    localparam int CNT_W = $clog2(NOTE_HOLD + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE, ISSUE} state_t;
    state_t state;

    logic [7:0]         key [VOICES];
    logic [AGE_W-1:0]   age [VOICES];
    logic [VOICES-1:0]  assigned;
    logic               lat_on;
    logic [7:0]         lat_key;
    logic [7:0]         lat_vel;
    logic [V_WIDTH-1:0] idx;
    logic               match_found, free_found, rel_found, held_found;
    logic [V_WIDTH-1:0] match_idx, free_idx, rel_idx, held_idx;
    logic [AGE_W-1:0]   rel_age, held_age;
    logic [CNT_W-1:0]   hold_cnt;
    logic               panic_pend;
    logic [V_WIDTH-1:0] tgt;
    logic               steal;

    always_comb begin
        tgt   = held_idx;
        steal = 1'b0;
        if (match_found)     tgt = match_idx;
        else if (free_found) tgt = free_idx;
        else if (rel_found)  tgt = rel_idx;
        else                 steal = 1'b1;
    end

    always_ff @(posedge OSC_CLK) begin
        if (iRST) begin
            state       <= IDLE;
            ev_ready    <= 1'b1;
            keys_on     <= '0;
            note_on     <= 1'b0;
            cur_key_adr <= '0;
            cur_key_val <= '0;
            cur_vel_on  <= 8'hFF;
            cur_vel_off <= '0;
            busy_err    <= 1'b0;
            assigned    <= '0;
            for (int v = 0; v < VOICES; v++) begin
                key[v] <= '0;
                age[v] <= '1;
            end
            lat_on      <= 1'b0;
            lat_key     <= '0;
            lat_vel     <= '0;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            held_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            rel_idx     <= '0;
            held_idx    <= '0;
            rel_age     <= '0;
            held_age    <= '0;
            hold_cnt    <= '0;
            panic_pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // panic outranks a simultaneous handshake
                    if (panic) begin
                        keys_on <= '0;
                    end else if (ev_valid) begin
                        lat_on      <= ev_is_on && (ev_vel != 8'd0);
                        lat_key     <= ev_key;
                        lat_vel     <= ev_vel;
                        ev_ready    <= 1'b0;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        rel_found   <= 1'b0;
                        held_found  <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (panic) begin
                        keys_on  <= '0;
                        ev_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        if (!match_found && assigned[idx] && key[idx] == lat_key) begin
                            match_found <= 1'b1;
                            match_idx   <= idx;
                        end
                        if (!free_found && voice_free[idx] && !keys_on[idx]) begin
                            free_found <= 1'b1;
                            free_idx   <= idx;
                        end
                        if (!keys_on[idx] && (!rel_found || age[idx] > rel_age)) begin
                            rel_found <= 1'b1;
                            rel_idx   <= idx;
                            rel_age   <= age[idx];
                        end
                        if (!held_found || age[idx] > held_age) begin
                            held_found <= 1'b1;
                            held_idx   <= idx;
                            held_age   <= age[idx];
                        end
                        if (idx == V_WIDTH'(VOICES - 1)) begin
                            idx   <= '0;
                            state <= DECIDE;
                        end else begin
                            idx <= idx + V_WIDTH'(1);
                        end
                    end
                end
                DECIDE: begin
                    if (panic) begin
                        keys_on  <= '0;
                        ev_ready <= 1'b1;
                        state    <= IDLE;
                    end else if (lat_on) begin
                        if (steal) busy_err <= 1'b1;
                        key[tgt]      <= lat_key;
                        assigned[tgt] <= 1'b1;
                        for (int v = 0; v < VOICES; v++) begin
                            if (v == int'(tgt))   age[v] <= '0;
                            else if (age[v] != '1) age[v] <= age[v] + AGE_W'(1);
                        end
                        keys_on[tgt] <= 1'b1;
                        cur_key_adr  <= tgt;
                        cur_key_val  <= lat_key;
                        cur_vel_on   <= lat_vel;
                        note_on      <= 1'b1;
                        hold_cnt     <= CNT_W'(NOTE_HOLD - 1);
                        state        <= ISSUE;
                    end else begin
                        if (match_found && keys_on[match_idx]) begin
                            keys_on[match_idx] <= 1'b0;
                            cur_key_adr        <= match_idx;
                            cur_vel_off        <= lat_vel;
                        end
                        ev_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                ISSUE: begin
                    if (panic) panic_pend <= 1'b1;
                    if (hold_cnt == '0) begin
                        note_on  <= 1'b0;
                        ev_ready <= 1'b1;
                        state    <= IDLE;
                        // deferred panic lands once the trigger pulse is complete
                        if (panic || panic_pend) begin
                            keys_on    <= '0;
                            panic_pend <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
